// File: rtl/viterbi_frame_ctrl.sv
// Viterbi frame controller: sequences clear/load/tail/drain around a
// fixed-latency decoder and re-times its bits onto a framed output.
module viterbi_frame_ctrl #(
  parameter int FRAME_LEN   = 32,
  parameter int TAIL_LEN    = 2,
  parameter int DEC_LATENCY = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [1:0] in_sym,
  input  logic       in_last,
  output logic       dec_clr,
  output logic [1:0] dec_sym,
  input  logic       dec_bit,
  output logic       out_valid,
  output logic       out_bit,
  output logic       out_last,
  output logic       busy,
  output logic       underrun,
  output logic       frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LOAD,
    S_TAIL,
    S_DRAIN
  } state_t;

  localparam logic [7:0] LoadEnd  = 8'(FRAME_LEN - 1);
  localparam logic [7:0] TailEnd  = 8'(TAIL_LEN - 1);
  localparam logic [7:0] DrainEnd = 8'(DEC_LATENCY);
  localparam int         TOP      = DEC_LATENCY - 1;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] sym_q, sym_d;
  logic       cur_dat_q, cur_dat_d;
  logic       cur_lst_q, cur_lst_d;
  logic [DEC_LATENCY-1:0] tdat_q, tdat_d;
  logic [DEC_LATENCY-1:0] tlst_q, tlst_d;
  logic       ov_q, ov_d;
  logic       ob_q, ob_d;
  logic       ol_q, ol_d;
  logic       ur_q, ur_d;
  logic       fe_q, fe_d;
  logic       in_load;
  logic       flush;
  logic       last_beat;

  assign in_load   = (state_q == S_LOAD);
  assign flush     = abort && (state_q != S_IDLE);
  assign last_beat = (cnt_q == LoadEnd);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = S_CLEAR;
          cnt_d   = 8'd0;
        end
      end
      S_CLEAR: begin
        state_d = S_LOAD;
        cnt_d   = 8'd0;
      end
      S_LOAD: begin
        if (last_beat) begin
          state_d = S_TAIL;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == TailEnd) begin
          state_d = S_DRAIN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == DrainEnd) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 8'd0;
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = 8'd0;
    end
  end

  // Tags ride alongside dec_sym so only load-phase bits reach the output.
  always_comb begin
    sym_d     = 2'b00;
    cur_dat_d = in_load;
    cur_lst_d = in_load && last_beat;
    tdat_d    = '0;
    tlst_d    = '0;
    if (in_load && in_valid) begin
      sym_d = in_sym;
    end
    tdat_d[0] = cur_dat_q;
    tlst_d[0] = cur_lst_q;
    for (int i = 1; i < DEC_LATENCY; i++) begin
      tdat_d[i] = tdat_q[i-1];
      tlst_d[i] = tlst_q[i-1];
    end
    ov_d = tdat_q[TOP];
    ob_d = tdat_q[TOP] & dec_bit;
    ol_d = tdat_q[TOP] & tlst_q[TOP];
    ur_d = ur_q;
    fe_d = fe_q;
    if ((state_q == S_IDLE) && in_valid) begin
      ur_d = 1'b0;
      fe_d = 1'b0;
    end
    if (in_load && !abort) begin
      if (!in_valid) begin
        ur_d = 1'b1;
      end else if (in_last != last_beat) begin
        fe_d = 1'b1;
      end
    end
    if (flush) begin
      sym_d     = 2'b00;
      cur_dat_d = 1'b0;
      cur_lst_d = 1'b0;
      tdat_d    = '0;
      tlst_d    = '0;
      ov_d      = 1'b0;
      ob_d      = 1'b0;
      ol_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      sym_q     <= 2'b00;
      cur_dat_q <= 1'b0;
      cur_lst_q <= 1'b0;
      tdat_q    <= '0;
      tlst_q    <= '0;
      ov_q      <= 1'b0;
      ob_q      <= 1'b0;
      ol_q      <= 1'b0;
      ur_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sym_q     <= sym_d;
      cur_dat_q <= cur_dat_d;
      cur_lst_q <= cur_lst_d;
      tdat_q    <= tdat_d;
      tlst_q    <= tlst_d;
      ov_q      <= ov_d;
      ob_q      <= ob_d;
      ol_q      <= ol_d;
      ur_q      <= ur_d;
      fe_q      <= fe_d;
    end
  end

  assign in_ready  = in_load;
  assign dec_clr   = (state_q == S_CLEAR);
  assign busy      = (state_q != S_IDLE);
  assign dec_sym   = sym_q;
  assign out_valid = ov_q;
  assign out_bit   = ob_q;
  assign out_last  = ol_q;
  assign underrun  = ur_q;
  assign frame_err = fe_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed + randomized bench for viterbi_frame_ctrl against a
// frame-level model and a delay-line decoder.
module tb_viterbi_frame_ctrl;

  localparam int N = 32;
  localparam int T = 2;
  localparam int L = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_sym;
  logic       in_last;
  logic       dec_clr;
  logic [1:0] dec_sym;
  logic       dec_bit;
  logic       out_valid;
  logic       out_bit;
  logic       out_last;
  logic       busy;
  logic       underrun;
  logic       frame_err;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  viterbi_frame_ctrl #(
    .FRAME_LEN(N),
    .TAIL_LEN(T),
    .DEC_LATENCY(L)
  ) dut (
    .clk(clk),
    .reset(rst_n),
    .abort(abort),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_sym(in_sym),
    .in_last(in_last),
    .dec_clr(dec_clr),
    .dec_sym(dec_sym),
    .dec_bit(dec_bit),
    .out_valid(out_valid),
    .out_bit(out_bit),
    .out_last(out_last),
    .busy(busy),
    .underrun(underrun),
    .frame_err(frame_err)
  );

  // Decoder stand-in: bit = msb of the symbol seen L cycles earlier.
  logic [1:0] hist [L] = '{default: 2'b00};
  always @(posedge clk) begin
    hist[0] <= dec_sym;
    for (int i = 1; i < L; i++) hist[i] <= hist[i-1];
  end
  assign dec_bit = hist[L-1][1];

  logic [1:0] got_q [$];
  bit         exp_q [$];
  int cyc = 0;
  int clr_cnt = 0;
  int tot_valid = 0;
  int tot_last = 0;
  int t0, t1, prev_t1;
  bit exp_uf, exp_fe;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (out_valid) begin
      got_q.push_back({out_bit, out_last});
      tot_valid++;
      if (out_last) tot_last++;
    end
    if (dec_clr) clr_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic zeros(input string tag);
    chk(tag, {in_ready, dec_clr, dec_sym, out_valid, out_bit,
              out_last, busy, underrun, frame_err}, 0);
  endtask

  // post: 0 = idle after frame, 1 = hold in_valid high, 2 = reset in drain
  task automatic run_frame(input int gap, input int lastb,
                           input int abort_at, input int post);
    bit v;
    bit saw_clr;
    logic [1:0] s;
    exp_q.delete();
    got_q.delete();
    clr_cnt = 0;
    exp_uf  = 0;
    exp_fe  = 0;
    saw_clr = 0;
    t0      = -1;
    in_valid = 1'b1;
    in_sym   = 2'b00;
    in_last  = 1'b0;
    for (int i = 0; i < 8 && !in_ready; i++) begin
      if (dec_clr && !saw_clr) begin
        saw_clr = 1;
        t0 = cyc;
      end
      @(negedge clk);
    end
    chk("load_start", in_ready, 1);
    chk("clr_before_load", saw_clr, 1);
    chk("flags_cleared", {underrun, frame_err}, 0);
    for (int k = 0; k < N; k++) begin
      v = (k != gap);
      s = 2'($urandom);
      in_valid = v;
      in_sym   = s;
      in_last  = (k == lastb);
      abort    = (k == abort_at);
      if (!v) exp_uf = 1;
      if (v && ((k == lastb) != (k == N - 1))) exp_fe = 1;
      exp_q.push_back(v ? s[1] : 1'b0);
      @(negedge clk);
      if (k == abort_at) begin
        abort    = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        got_q.delete();
        chk("abort_idle", busy, 0);
        chk("abort_ov", out_valid, 0);
        repeat (40) @(negedge clk);
        chk("abort_no_out", got_q.size(), 0);
        chk("abort_flags", {underrun, frame_err}, {exp_uf, exp_fe});
        return;
      end
      chk("dec_sym", dec_sym, v ? s : 2'b00);
    end
    in_valid = (post == 1);
    in_sym   = 2'b00;
    in_last  = 1'b0;
    if (post == 2) begin
      repeat (T + 5) @(negedge clk);
      chk("pre_reset_uf", underrun, exp_uf);
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1 zeros("reset_in_drain");
      @(negedge clk);
      rst_n = 1'b1;
      return;
    end
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    t1 = cyc;
    chk("busy_drop", busy, 0);
    chk("busy_len", t1 - t0, 1 + N + T + L + 1);
    chk("clr_cnt", clr_cnt, 1);
    chk("out_count", got_q.size(), N);
    for (int k = 0; k < N && k < got_q.size(); k++)
      chk("out_bit_last", got_q[k], {exp_q[k], 1'(k == N - 1)});
    chk("underrun", underrun, exp_uf);
    chk("frame_err", frame_err, exp_fe);
  endtask

  initial begin
    int g, lb;
    rst_n    = 1'b0;
    abort    = 1'b0;
    in_valid = 1'b0;
    in_sym   = 2'b00;
    in_last  = 1'b0;
    #1 zeros("reset_state");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    zeros("idle_after_reset");

    run_frame(-1, N - 1, -1, 0);

    run_frame(10, N - 1, -1, 0);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_sticky", underrun, 1);

    run_frame(-1, 5, -1, 0);

    run_frame(-1, N - 1, 20, 0);
    run_frame(-1, N - 1, -1, 0);

    run_frame(7, N - 1, -1, 2);
    run_frame(-1, N - 1, -1, 0);

    tot_valid = 0;
    tot_last  = 0;
    run_frame(-1, N - 1, -1, 1);
    prev_t1 = t1;
    run_frame(-1, N - 1, -1, 0);
    chk("b2b_turnaround", t0 - prev_t1, 1);
    chk("b2b_valid", tot_valid, 2 * N);
    chk("b2b_last", tot_last, 2);

    for (int r = 0; r < 4; r++) begin
      g  = int'($urandom_range(0, 2 * N - 1));
      lb = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, N - 1))
                                       : N - 1;
      @(negedge clk);
      run_frame(g, lb, -1, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/viterbi_frame_ctrl.md
VITERBI_FRAME_CTRL -- requirements
Module: viterbi_frame_ctrl

Interface
REQ-001 The block SHALL have parameter FRAME_LEN, default 32, meaning data symbols per frame (2..255).
REQ-002 The block SHALL have parameter TAIL_LEN, default 2, meaning zero-symbols flushed after each frame (1..15).
REQ-003 The block SHALL have parameter DEC_LATENCY, default 15, meaning cycles from symbol on dec_sym to its bit on dec_bit (1..31).
REQ-004 Ports SHALL be:
  clk          in   1  single clock, all logic rising-edge
  reset        in   1  asynchronous, active-low; low = reset
  abort        in   1  synchronous frame abort, active-high
  in_valid     in   1  upstream symbol valid
  in_ready     out  1  symbol accepted when in_valid & in_ready at clk edge
  in_sym       in   2  encoded symbol pair
  in_last      in   1  upstream marks final symbol of frame
  dec_clr      out  1  one-cycle decoder/path-metric clear pulse
  dec_sym      out  2  symbol driven to the decoder, registered
  dec_bit      in   1  decoded bit from the decoder
  out_valid    out  1  out_bit valid, registered
  out_bit      out  1  decoded data bit
  out_last     out  1  with out_valid, marks final data bit of frame
  busy         out  1  high in any state except IDLE
  underrun     out  1  sticky: in_valid low during LOAD
  frame_err    out  1  sticky: in_last misplaced or missing

Function
REQ-005 States SHALL be IDLE, CLEAR, LOAD, TAIL, DRAIN.
REQ-006 IDLE: in_ready=0; in_valid=1 -> CLEAR next cycle; underrun and frame_err cleared on that transition.
REQ-007 CLEAR: dec_clr=1 for exactly this one cycle, dec_sym=00, in_ready=0; -> LOAD unconditionally.
REQ-008 LOAD: in_ready=1; lasts exactly FRAME_LEN cycles; the decoder advances every clock, so the symbol counter increments every LOAD cycle whether or not a symbol is accepted.
REQ-009 In LOAD, on accept, dec_sym SHALL take in_sym at that edge; on a cycle with in_valid=0, dec_sym SHALL take 00 and underrun SHALL set.
REQ-010 frame_err SHALL set on an accepted in_last=1 when counter != FRAME_LEN-1, or on an accepted beat at counter FRAME_LEN-1 with in_last=0.
REQ-011 After LOAD cycle FRAME_LEN-1 -> TAIL: in_ready=0, dec_sym=00 for exactly TAIL_LEN cycles -> DRAIN.
REQ-012 DRAIN SHALL last DEC_LATENCY+1 cycles, dec_sym=00, in_ready=0, then -> IDLE.
REQ-013 A tag pipeline of depth DEC_LATENCY SHALL carry (data, last) per dec_sym cycle; data=1 only for LOAD symbols, last=1 only for symbol FRAME_LEN-1.
REQ-014 The bit on dec_bit in cycle c+DEC_LATENCY belongs to dec_sym of cycle c; out_valid/out_bit/out_last SHALL register it at the end of cycle c+DEC_LATENCY only if its tag data=1.
REQ-015 Exactly FRAME_LEN out_valid pulses per frame, contiguous, with out_last on the last; tail and clear-cycle bits SHALL never reach out_valid.
REQ-016 Frame-to-frame turnaround: IDLE entered after last out_valid; in_valid held high yields CLEAR on the following cycle; no overlap of frames.
REQ-017 abort=1 in any state SHALL force IDLE next edge, flush all tags to 0, drop out_valid next edge, leave sticky flags unchanged; abort in IDLE has no effect.
REQ-018 Counters SHALL be 8 bits, compare-based; no wrap occurs within legal parameter ranges.

Reset
REQ-019 reset low SHALL immediately force IDLE, counters 0, tags 0, and in_ready, dec_clr, dec_sym, out_valid, out_bit, out_last, busy, underrun, frame_err all 0.
REQ-020 Reset asserted mid-frame SHALL discard the frame; after release the next frame begins only via IDLE->CLEAR.

Verification
REQ-021 Clean frame, FRAME_LEN=32, in_valid always 1, in_last on beat 31, decoder model = delay of DEC_LATENCY -> one dec_clr, 32 out_valid bits matching data, out_last on the 32nd, flags 0, busy low after 1+32+2+16 cycles.
REQ-022 in_valid low on LOAD beat 10 -> dec_sym=00 that cycle, underrun=1 sticky until next IDLE->CLEAR, still exactly 32 out_valid.
REQ-023 in_last on beat 5 -> frame_err=1; frame still runs 32 beats.
REQ-024 abort in LOAD beat 20 -> IDLE next cycle, out_valid stays 0 afterward, no out_last; next frame decodes cleanly.
REQ-025 reset low during DRAIN -> all outputs 0 immediately; after release and in_valid=1, dec_clr pulses before any LOAD.
REQ-026 Back-to-back frames with in_valid held high -> CLEAR one cycle after IDLE entry, 64 total out_valid, two out_last.
